// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC job sequencer: FSM state encoding,
// default lane count and the 2-bit ternary weight encoding used by the array.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACC   = 3'd2,
    ST_COPY  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int LANES_DEFAULT = 4;

  localparam logic [1:0] W_ZERO    = 2'b00;
  localparam logic [1:0] W_POS     = 2'b01;
  localparam logic       W_NEG_MSB = 1'b1;

  // Signed value of one packed ternary weight; any code with the MSB set is -1.
  function automatic logic signed [1:0] ternary_of(input logic [1:0] code);
    if (code[1] == W_NEG_MSB) return -2'sd1;
    if (code == W_POS)        return 2'sd1;
    return 2'sd0;
  endfunction

  // Weights reach the array only on an accepted beat; otherwise all lanes see zero
  // so the accumulators hold their value.
  function automatic logic [7:0] gate_weights(input logic fire, input logic [7:0] w);
    return fire ? w : {4{W_ZERO}};
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Host/array-facing signal bundle of the MAC job sequencer. The sequencer
// uses the slave view; the host side (chip I/O glue or a bench) uses master.
interface mac_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int LANES = 4
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_weights;
  logic [7:0]        in_act;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic [LANE_W-1:0] out_lane;
  logic [7:0]        arr_weights;
  logic [7:0]        arr_act;
  logic              arr_reset_acc;
  logic              arr_copy;
  logic              arr_restart;

  modport master (
    output start, cfg_len, abort, in_valid, in_weights, in_act,
    input  in_ready, busy, done, out_valid, out_lane,
    input  arr_weights, arr_act, arr_reset_acc, arr_copy, arr_restart
  );

  modport slave (
    input  start, cfg_len, abort, in_valid, in_weights, in_act,
    output in_ready, busy, done, out_valid, out_lane,
    output arr_weights, arr_act, arr_reset_acc, arr_copy, arr_restart
  );

endinterface

// File: rtl/mac_seq_counter.sv
// Loadable counter with a zero flag. Down variant saturates at zero; the
// up variant (UP=1) wraps naturally at its width.
module mac_seq_counter #(
  parameter int W  = 8,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      if (UP) begin
        r_cnt <= r_cnt + W'(1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - W'(1);
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Job controller for the ternary MAC systolic array: clear, stream beats,
// snapshot the accumulators and drain one result byte per lane.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int LANES = LANES_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  mac_sequencer_if.slave bus
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_clear;
  logic              r_acc;
  logic              r_copy;
  logic              r_drain;
  logic              r_busy;

  logic              w_fire;
  logic              w_load;
  logic              w_cnt_zero;
  logic              w_lane_last;
  logic [LANE_W-1:0] w_lane;
  logic [LEN_W-1:0]  w_unused_cnt;
  logic              w_unused_lane_zero;

  assign w_fire      = r_acc & bus.in_valid & ~bus.abort;
  assign w_load      = (r_state == ST_IDLE) & bus.start & ~bus.abort;
  assign w_lane_last = (w_lane == LANE_W'(LANES - 1));

  mac_seq_counter #(.W(LEN_W), .UP(1'b0)) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (bus.cfg_len),
    .i_en       (w_fire),
    .o_cnt      (w_unused_cnt),
    .o_zero     (w_cnt_zero)
  );

  // The lane index is reloaded in COPY so it reads 0 on the first DRAIN cycle.
  mac_seq_counter #(.W(LANE_W), .UP(1'b1)) u_lane_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_copy),
    .i_load_val ('0),
    .i_en       (r_drain),
    .o_cnt      (w_lane),
    .o_zero     (w_unused_lane_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != ST_IDLE && bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_load) w_state_nxt = ST_CLEAR;
        ST_CLEAR: w_state_nxt = ST_ACC;
        ST_ACC:   if (w_fire && w_cnt_zero) w_state_nxt = ST_COPY;
        ST_COPY:  w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_lane_last) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and its Moore decodes are registered together so array controls are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_clear <= 1'b0;
      r_acc   <= 1'b0;
      r_copy  <= 1'b0;
      r_drain <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clear <= (w_state_nxt == ST_CLEAR);
      r_acc   <= (w_state_nxt == ST_ACC);
      r_copy  <= (w_state_nxt == ST_COPY);
      r_drain <= (w_state_nxt == ST_DRAIN);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // abort kills handshake and output strobes in the same cycle it is raised.
  assign bus.in_ready      = r_acc & ~bus.abort;
  assign bus.arr_weights   = gate_weights(w_fire, bus.in_weights);
  assign bus.arr_act       = bus.in_act;
  assign bus.arr_reset_acc = r_clear;
  assign bus.arr_copy      = r_copy;
  assign bus.arr_restart   = r_copy;
  assign bus.busy          = r_busy;
  assign bus.out_valid     = r_drain & ~bus.abort;
  assign bus.out_lane      = r_drain ? w_lane : '0;
  assign bus.done          = r_drain & w_lane_last & ~bus.abort;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural stand-in for the
// ternary systolic array attached to its array-side outputs.
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_sequencer_if #(.LEN_W(8), .LANES(4)) bus ();

  mac_sequencer #(.LEN_W(8), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    int         lane;
    logic [7:0] b;
    logic       done;
  } ev_t;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        out_q[$];
  int         clr_q[$];
  int         cp_q[$];
  ev_t        ev;
  int         exp_cyc;
  logic [7:0] job_w[256];
  logic [7:0] job_a[256];
  int         acc[4];
  int         snap[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tern(input logic [1:0] c);
    if (c[1]) return -1;
    if (c[0]) return 1;
    return 0;
  endfunction

  function automatic logic [7:0] res_byte(input int s);
    int t;
    t = s >>> 8;
    return t[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Array stand-in: lane l multiplies weight bits [7-2l -: 2] by the signed activation.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (!rst_n || bus.arr_reset_acc) acc[l] <= 0;
      else acc[l] <= acc[l] + tern(bus.arr_weights[7-2*l -: 2]) * int'($signed(bus.arr_act));
      if (rst_n && bus.arr_copy) snap[l] <= acc[l];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("arr_act", bus.arr_act, bus.in_act);
      chk("restart_eq_copy", bus.arr_restart, bus.arr_copy);
      if (!bus.in_ready) chk("wgt_gate", bus.arr_weights, 0);
      if (bus.out_valid) begin
        n_cmp++;
        if (out_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: got lane %0d at cycle %0d, want no output", bus.out_lane, cyc);
        end else begin
          ev = out_q.pop_front();
          if (cyc != ev.cyc || int'(bus.out_lane) != ev.lane || res_byte(snap[bus.out_lane]) != ev.b
              || bus.done != ev.done) begin
            n_bad++;
            $display("FAIL out_event: got cyc=%0d lane=%0d byte=%h done=%b, want cyc=%0d lane=%0d byte=%h done=%b",
                     cyc, bus.out_lane, res_byte(snap[bus.out_lane]), bus.done, ev.cyc, ev.lane, ev.b, ev.done);
          end
        end
      end else if (bus.done) begin
        chk("done_without_valid", bus.done, 0);
      end
      if (bus.arr_reset_acc) begin
        exp_cyc = (clr_q.size() != 0) ? clr_q.pop_front() : -1;
        chk("clear_cycle", cyc, exp_cyc);
      end
      if (bus.arr_copy) begin
        exp_cyc = (cp_q.size() != 0) ? cp_q.pop_front() : -1;
        chk("copy_cycle", cyc, exp_cyc);
      end
    end
  end

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      job_w[i] = 8'($urandom);
      job_a[i] = 8'($urandom);
    end
  endtask

  // Entered and left just after a rising edge with the sequencer idle.
  task automatic run_job(input int n, input int stall_at, input int stall_cnt, input int stall_pct,
                         input int abort_beat, input int abort_lane, input int rst_lane,
                         input bit start_in_drain);
    int base, s, nst, last;
    int sum[4];
    base = cyc;
    s = 0;
    for (int l = 0; l < 4; l++) sum[l] = 0;
    bus.start = 1'b1;
    bus.cfg_len = 8'(n - 1);
    clr_q.push_back(base + 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'($urandom);
    bus.in_weights = 8'($urandom);
    @(negedge clk);
    chk("clear_rdy", bus.in_ready, 0);
    chk("clear_busy", bus.busy, 1);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      nst = (i == stall_at) ? stall_cnt : (($urandom_range(99) < stall_pct) ? $urandom_range(1, 2) : 0);
      for (int k = 0; k < nst; k++) begin
        bus.in_valid = 1'b0;
        bus.in_weights = 8'($urandom) | 8'h01;
        bus.in_act = 8'($urandom);
        @(negedge clk);
        chk("stall_rdy", bus.in_ready, 1);
        chk("stall_wgt", bus.arr_weights, 0);
        @(posedge clk); #1;
        s++;
      end
      if (i == abort_beat) begin
        bus.in_valid = 1'b1;
        bus.abort = 1'b1;
        bus.in_weights = 8'h55;
        @(negedge clk);
        chk("abort_rdy", bus.in_ready, 0);
        chk("abort_wgt", bus.arr_weights, 0);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", bus.busy, 0);
        @(posedge clk); #1;
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_weights = job_w[i];
      bus.in_act = job_a[i];
      for (int l = 0; l < 4; l++) sum[l] += tern(job_w[i][7-2*l -: 2]) * int'($signed(job_a[i]));
      @(negedge clk);
      chk("beat_rdy", bus.in_ready, 1);
      chk("beat_wgt", bus.arr_weights, job_w[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_weights = 8'($urandom);
    bus.in_act = 8'($urandom);
    cp_q.push_back(base + n + 2 + s);
    last = (abort_lane >= 0) ? abort_lane : ((rst_lane >= 0) ? rst_lane : 4);
    for (int j = 0; j < last; j++)
      out_q.push_back('{cyc: base + n + 3 + s + j, lane: j, b: res_byte(sum[j]), done: (j == 3)});
    @(negedge clk);
    chk("copy_rdy", bus.in_ready, 0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (start_in_drain && j == 1) begin
        bus.start = 1'b1;
        bus.cfg_len = 8'($urandom);
      end
      if (j == abort_lane) begin
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_drain_valid", bus.out_valid, 0);
        chk("abort_drain_done", bus.done, 0);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_drain_idle", bus.busy, 0);
        @(posedge clk); #1;
        return;
      end
      if (j == rst_lane) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lane", bus.out_lane, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", bus.busy, 0);
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_end", bus.busy, 0);
    chk("end_cycle", cyc, base + n + 7 + s);
    if (start_in_drain) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain_start_ignored", bus.busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_weights = 8'hA5;
    bus.in_act = 8'h3C;
    #3;
    chk("reset_busy", bus.busy, 0);
    chk("reset_ready", bus.in_ready, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_lane", bus.out_lane, 0);
    chk("reset_wgt", bus.arr_weights, 0);
    chk("reset_ctl", {bus.arr_reset_acc, bus.arr_copy, bus.arr_restart}, 0);
    chk("reset_act", bus.arr_act, 8'h3C);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin job_w[i] = 8'h55; job_a[i] = 8'h7F; end
    run_job(4, -1, 0, 0, -1, -1, -1, 1'b0);
    run_job(4, 1, 2, 0, -1, -1, -1, 1'b0);
    job_w[0] = 8'hB1; job_a[0] = 8'h80;
    run_job(1, -1, 0, 0, -1, -1, -1, 1'b0);
    fill_rand(4);
    run_job(4, -1, 0, 0, 2, -1, -1, 1'b0);
    fill_rand(1);
    run_job(1, -1, 0, 0, -1, -1, -1, 1'b0);
    fill_rand(5);
    run_job(5, -1, 0, 20, -1, -1, -1, 1'b1);
    fill_rand(3);
    run_job(3, -1, 0, 0, -1, 2, -1, 1'b0);
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_rand(n);
      run_job(n, -1, 0, 30, -1, -1, -1, 1'b0);
    end
    fill_rand(3);
    run_job(3, -1, 0, 0, -1, -1, 1, 1'b0);
    fill_rand(256);
    run_job(256, -1, 0, 0, -1, -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("out_q_left", out_q.size(), 0);
    chk("clr_q_left", clr_q.size(), 0);
    chk("cp_q_left", cp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Job controller for the ternary 4-lane MAC systolic array. It accepts a job start with a beat count. It clears the accumulators, streams weight/activation beats into the array with a valid/ready handshake, and forces all-zero weights on stall cycles so the accumulators hold. It then snapshots the accumulators into the array's output queue and drains the 4 result bytes with a valid strobe and lane tag. It sits between the chip-level I/O and the array, and replaces the fixed `ena`-tied control.

## Interface
- `LEN_W`, 8: width of the beat-count field. A job is 1..2^LEN_W beats.
- `LANES`, 4: number of array rows (result bytes per job).
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `start`  in  1  job request, sampled in IDLE only
- `cfg_len`  in  LEN_W  beats minus one, sampled with `start`
- `abort`  in  1  cancel the current job, any state
- `in_valid`  in  1  beat offered
- `in_weights`  in  8  4 packed 2-bit ternary weights: 00=0, 01=+1, 1x=-1
- `in_act`  in  8  signed activation
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse, coincident with the last result byte
- `out_valid`  out  1  `arr_out` holds result byte for `out_lane`
- `out_lane`  out  2  lane index of the current result byte
- `arr_weights`  out  8  to array weight input
- `arr_act`  out  8  to array activation input; always equals `in_act`
- `arr_reset_acc`  out  1  to array `reset_accumulators`
- `arr_copy`  out  1  to array `copy_accumulator_values_to_out_queue`
- `arr_restart`  out  1  to array `restart_out_queue`

## Operation
- States: IDLE, CLEAR, ACC, COPY, DRAIN.
- **IDLE**: on `start & ~abort`, latch `cnt <= cfg_len` and go to CLEAR. A `start` seen in any other state is ignored.
- **CLEAR**: one cycle, `arr_reset_acc=1`, then go to ACC.
- **ACC**:
  - `in_ready = ~abort`.
  - `arr_weights = (in_valid & in_ready) ? in_weights : 8'h00`, so a stall or abort leaves the accumulators unchanged.
  - Each accepted beat decrements `cnt`.
  - The beat accepted when `cnt==0` is the last one; go to COPY.
- **COPY**: one cycle, `arr_copy=1` and `arr_restart=1`. The snapshot includes the last beat. The queue index is 0 on the next cycle. Set `lane <= 0` and go to DRAIN.
- **DRAIN**: `LANES` cycles.
  - `out_valid=1`, `out_lane=lane`, `lane` increments each cycle.
  - There is no backpressure, because the array queue index free-runs.
  - On `lane==LANES-1`, pulse `done` and go to IDLE.
- **Abort**: from any non-IDLE state, go to IDLE next cycle.
  - No `done` pulse.
  - `out_valid` and `in_ready` drop combinationally in the abort cycle.
  - The next job's CLEAR discards any partial sums.
- **Outside ACC**: `in_ready=0` and `arr_weights=8'h00`.
- **Reset** (async, any state including mid-job): state=IDLE, `cnt=0`, `lane=0`. All outputs are 0 except `arr_act`, which follows `in_act`.
- **Width rules**: `cnt` is LEN_W bits and never wraps, because it stops at 0. `lane` is log2(LANES) bits and wraps only on the terminal cycle.

## Timing
- Edge 0: `start` sampled. Cycle 1: CLEAR. Cycles 2..: ACC.
- With no stalls, an N-beat job (`cfg_len=N-1`) gives:
  - COPY at cycle N+2.
  - DRAIN at cycles N+3..N+6.
  - `done` at cycle N+6.
  - `busy` low at cycle N+7.
- Each stall cycle in ACC adds one cycle to every later milestone.
- Back-to-back jobs:
  - Earliest `start` acceptance is the first IDLE cycle after `done`.
  - Minimum job period is N+7 cycles.
- All control outputs to the array are Moore decodes of state, except `in_ready` and `arr_weights`, which also depend on `abort`/`in_valid`. This gives a zero-cycle path from `in_valid` to the array.

## Structure
- Package `mac_seq_pkg` holds:
  - the state enum (IDLE, CLEAR, ACC, COPY, DRAIN);
  - `LANES_DEFAULT=4`;
  - the weight encoding constants `W_ZERO=2'b00`, `W_POS=2'b01`, `W_NEG_MSB=1'b1`.
- One sub-module, `mac_seq_counter`: a loadable down-counter with a zero flag. It is instantiated twice, once for beat count (LEN_W) and once for drain lane (log2 LANES, count-up variant via parameter).
- Top-level integration wires this block between `ui_in`/`uio_in` and `systolic_array`. The array keeps its synchronous `reset = ~rst_n`.

## Test plan
- **Basic job.** Stimulus: `cfg_len=3`; 4 beats with `in_act=8'h7F` and `in_weights=8'h55` (all +1), `in_valid` held high. Required response:
  - `arr_reset_acc` at cycle 1;
  - `arr_copy`/`arr_restart` at cycle 6;
  - `out_valid` at cycles 7..10 with `out_lane` 0,1,2,3;
  - `done` at cycle 10;
  - with the array attached, each byte = 508>>8 = 8'h01.
- **Stalls.** Same job with `in_valid` low for 2 cycles after beat 1. Required response: `arr_weights=8'h00` in both stall cycles, `done` at cycle 12, result bytes unchanged.
- **Mixed signs.** `cfg_len=0`, `in_weights=8'hB1` (lanes -1,-1,0,+1 in array order), `in_act=8'h80`. Required response: single-beat job with `done` at cycle 7; array result bytes 8'h00, 8'h00, 8'h00, 8'hFF.
- **Abort and ignored start.** Abort during ACC after 2 beats:
  - `in_ready` drops in the abort cycle;
  - IDLE next cycle;
  - no `done` pulse.
  - A following `start` with `cfg_len=0` gives a fresh result, with no residue from the aborted job.
  - A `start` asserted during DRAIN is ignored: `busy` falls after `done` with no second job.
- **Asynchronous reset.** Assert `rst_n=0` mid-DRAIN, between clock edges. Required response:
  - outputs clear immediately;
  - `out_valid=0` and `busy=0`;
  - after release, `cfg_len=255` runs 256 beats and gives `done` at cycle 262.
